// File: rtl/div3_checker.sv
// div3_checker: iterated |odd popcount - even popcount| reduction that flags operands divisible by 3.
// Optional iteration counter is enabled by DIV3_CHECKER_ITERS_EN; when undefined, out_iters is tied to 0.
module div3_checker #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_div3,
   output logic [CNT_W-1:0] out_iters,
   output logic             out_valid,
   input  logic             out_ready
);
   localparam int SW = $clog2(WIDTH / 2 + 1);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] val, step_val;
   logic [SW-1:0] odd_sum, even_sum;
   logic term;
   always_comb begin
      odd_sum = '0;
      even_sum = '0;
      for (int i = 0; i < WIDTH / 2; i++) begin
         odd_sum = odd_sum + SW'(val[2*i+1]);
         even_sum = even_sum + SW'(val[2*i]);
      end
      step_val = WIDTH'(odd_sum >= even_sum ? odd_sum - even_sum : even_sum - odd_sum);
      term = val < WIDTH'(3);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_comb
      state_nx = state == IDLE ? ((in_valid && in_ready) ? BUSY : IDLE) :
                 state == BUSY ? (term ? DONE : BUSY) :
                 (out_ready ? IDLE : DONE);
   // in_ready is also gated by rst so every output reads 0 while reset is held
   always_comb begin
      in_ready = (state == IDLE) && !rst;
      out_valid = state == DONE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         val <= '0;
         out_div3 <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         val <= in_data;
      end else if (state == BUSY) begin
         if (term) out_div3 <= val == '0;
         else val <= step_val;
      end
`ifdef DIV3_CHECKER_ITERS_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) out_iters <= '0;
      else if (state == IDLE && in_valid) out_iters <= '0;
      else if (state == BUSY && !term && out_iters != '1) out_iters <= out_iters + 1'b1;
`else
   assign out_iters = '0;
`endif
endmodule
